// File: rtl/riscv_pipe_pkg.sv
// riscv_pipe_pkg -- shared types and defaults for the instruction fetch path.
//   ipq_state_e : prefetch queue control states (BOOT, RUN, FLUSH)
//   IPQ_DEPTH / IPQ_PC_W / IPQ_RESET_PC : default queue geometry and boot PC
package riscv_pipe_pkg;

  typedef enum logic [1:0] {
    IPQ_BOOT  = 2'd0,
    IPQ_RUN   = 2'd1,
    IPQ_FLUSH = 2'd2
  } ipq_state_e;

  localparam int IPQ_DEPTH    = 4;
  localparam int IPQ_PC_W     = 12;
  localparam int IPQ_RESET_PC = 0;

endpackage

// File: rtl/ipq_fifo.sv
// ipq_fifo -- instruction/PC storage for the prefetch queue.
//   clk, rst_n      : clock, async active-low reset (storage cleared too so the
//                     head reads as zero out of reset)
//   i_clr           : synchronous flush, wins over push/pop
//   i_push, i_instr, i_pc : write tail entry
//   i_pop           : retire head entry (caller guarantees non-empty)
//   o_instr, o_pc   : head entry
//   o_count, o_empty: occupancy
module ipq_fifo
  import riscv_pipe_pkg::*;
#(
  parameter int DEPTH = IPQ_DEPTH,
  parameter int PC_W  = IPQ_PC_W
)(
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_clr,
  input  logic                       i_push,
  input  logic [31:0]                i_instr,
  input  logic [PC_W-1:0]            i_pc,
  input  logic                       i_pop,
  output logic [31:0]                o_instr,
  output logic [PC_W-1:0]            o_pc,
  output logic [$clog2(DEPTH+1)-1:0] o_count,
  output logic                       o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [31:0]     r_instr [DEPTH];
  logic [PC_W-1:0] r_pc    [DEPTH];
  logic [AW-1:0]   r_wr, r_rd;
  logic [CW-1:0]   r_cnt;

  // DEPTH is a power of two, so the pointers wrap by overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_instr[i] <= '0;
        r_pc[i]    <= '0;
      end
    end else if (i_clr) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (i_push) begin
        r_instr[r_wr] <= i_instr;
        r_pc[r_wr]    <= i_pc;
        r_wr          <= r_wr + AW'(1);
      end
      if (i_pop) r_rd <= r_rd + AW'(1);
      case ({i_push, i_pop})
        2'b10:   r_cnt <= r_cnt + CW'(1);
        2'b01:   r_cnt <= r_cnt - CW'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  assign o_instr = r_instr[r_rd];
  assign o_pc    = r_pc[r_rd];
  assign o_count = r_cnt;
  assign o_empty = (r_cnt == '0);

endmodule

// File: rtl/instr_prefetch_queue.sv
// instr_prefetch_queue -- sequential instruction prefetcher with branch flush.
// Issues word-aligned fetches while queued + in-flight words fit in DEPTH,
// queues returned words with their PC, and on a taken branch drops the queue
// and every response still in flight.
//   clk, rst_n                 : clock, async active-low reset
//   req_valid/req_addr/req_ready : fetch request to instruction memory
//   resp_valid/resp_data       : in-order responses from memory
//   redirect/redirect_pc       : taken branch and its target
//   out_valid/out_instr/out_pc/out_ready : head entry toward fetch/decode
// Optional (macro IPQ_PERF_CNT_EN): perf_empty_cnt, perf_flush_cnt,
//   16-bit saturating counters of starved cycles and redirects.
module instr_prefetch_queue
  import riscv_pipe_pkg::*;
#(
  parameter int              DEPTH    = IPQ_DEPTH,
  parameter int              PC_W     = IPQ_PC_W,
  parameter logic [PC_W-1:0] RESET_PC = PC_W'(IPQ_RESET_PC)
)(
  input  logic            clk,
  input  logic            rst_n,
  output logic            req_valid,
  output logic [PC_W-1:0] req_addr,
  input  logic            req_ready,
  input  logic            resp_valid,
  input  logic [31:0]     resp_data,
  input  logic            redirect,
  input  logic [PC_W-1:0] redirect_pc,
  output logic            out_valid,
  output logic [31:0]     out_instr,
  output logic [PC_W-1:0] out_pc,
  input  logic            out_ready
`ifdef IPQ_PERF_CNT_EN
  ,
  output logic [15:0]     perf_empty_cnt,
  output logic [15:0]     perf_flush_cnt
`endif
);

  localparam int            CW       = $clog2(DEPTH+1);
  localparam logic [CW:0]   LP_DEPTH = DEPTH[CW:0];

  ipq_state_e      r_state;
  logic [PC_W-1:0] r_pc;
  logic [CW-1:0]   r_out;     // requests accepted, response not yet seen
  logic [CW-1:0]   r_drop;    // stale responses still to discard

  logic [CW-1:0]   w_occ;
  logic            w_empty;
  logic [CW:0]     w_inflight;
  logic            w_acc, w_resp_cnt, w_push, w_pop;
  logic [CW-1:0]   w_out_nxt;
  logic [PC_W-1:0] w_resp_pc;

  assign w_inflight = {1'b0, w_occ} + {1'b0, r_out};
  assign req_valid  = (r_state == IPQ_RUN) && (w_inflight < LP_DEPTH);
  assign req_addr   = r_pc;
  assign w_acc      = req_valid && req_ready;

  // With outstanding at zero a response can only belong to a request issued
  // before reset, so it is dropped without touching the counters.
  assign w_resp_cnt = resp_valid && (r_out != '0);
  assign w_push     = w_resp_cnt && !redirect && (r_state == IPQ_RUN);
  assign w_pop      = out_valid && out_ready && !redirect;
  assign w_out_nxt  = r_out + CW'(w_acc) - CW'(w_resp_cnt);

  // In RUN every in-flight request is part of the current sequential run
  // ending at r_pc-4, so the oldest one sits at r_pc - 4*outstanding.
  assign w_resp_pc  = r_pc - PC_W'({r_out, 2'b00});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IPQ_BOOT;
      r_pc    <= RESET_PC;
      r_out   <= '0;
      r_drop  <= '0;
    end else begin
      r_out <= w_out_nxt;
      if (redirect) begin
        // A request accepted this cycle and a coincident response are both
        // stale; w_out_nxt already folds them in.
        r_pc    <= redirect_pc;
        r_drop  <= w_out_nxt;
        r_state <= (w_out_nxt != '0) ? IPQ_FLUSH : IPQ_RUN;
      end else begin
        case (r_state)
          IPQ_BOOT: r_state <= IPQ_RUN;
          IPQ_RUN:  if (w_acc) r_pc <= r_pc + PC_W'(4);
          IPQ_FLUSH: begin
            if (resp_valid && r_drop != '0) r_drop <= r_drop - CW'(1);
            if (r_drop == '0 || (resp_valid && r_drop == CW'(1)))
              r_state <= IPQ_RUN;
          end
          default:  r_state <= IPQ_BOOT;
        endcase
      end
    end
  end

  ipq_fifo #(.DEPTH(DEPTH), .PC_W(PC_W)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clr   (redirect),
    .i_push  (w_push),
    .i_instr (resp_data),
    .i_pc    (w_resp_pc),
    .i_pop   (w_pop),
    .o_instr (out_instr),
    .o_pc    (out_pc),
    .o_count (w_occ),
    .o_empty (w_empty)
  );

  assign out_valid = !w_empty;

`ifdef IPQ_PERF_CNT_EN
  logic [15:0] r_perf_empty, r_perf_flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perf_empty <= '0;
      r_perf_flush <= '0;
    end else begin
      if (out_ready && !out_valid && r_perf_empty != 16'hFFFF)
        r_perf_empty <= r_perf_empty + 16'd1;
      if (redirect && r_perf_flush != 16'hFFFF)
        r_perf_flush <= r_perf_flush + 16'd1;
    end
  end

  assign perf_empty_cnt = r_perf_empty;
  assign perf_flush_cnt = r_perf_flush;
`endif

endmodule

// File: tb/tb_instr_prefetch_queue.sv
// tb_instr_prefetch_queue -- randomized bench for instr_prefetch_queue.
// Memory is an in-order latency model whose data encodes the address; the
// reference model is the expected program-order PC stream after the last
// redirect, so any stale or skipped instruction shows up on the next pop.
module tb_instr_prefetch_queue;
  import riscv_pipe_pkg::*;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid;
  logic [11:0] req_addr;
  logic        req_ready = 1'b0;
  logic        resp_valid = 1'b0;
  logic [31:0] resp_data = '0;
  logic        redirect = 1'b0;
  logic [11:0] redirect_pc = '0;
  logic        out_valid;
  logic [31:0] out_instr;
  logic [11:0] out_pc;
  logic        out_ready = 1'b0;
`ifdef IPQ_PERF_CNT_EN
  logic [15:0] perf_empty_cnt, perf_flush_cnt;
`endif

  instr_prefetch_queue #(.DEPTH(DEPTH), .PC_W(12), .RESET_PC(12'h000)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_addr    (req_addr),
    .req_ready   (req_ready),
    .resp_valid  (resp_valid),
    .resp_data   (resp_data),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .out_valid   (out_valid),
    .out_instr   (out_instr),
    .out_pc      (out_pc),
    .out_ready   (out_ready)
`ifdef IPQ_PERF_CNT_EN
    ,
    .perf_empty_cnt (perf_empty_cnt),
    .perf_flush_cnt (perf_flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] addr;
    int          due;
  } mreq_t;

  mreq_t       pend[$];
  logic [11:0] em_pc[$];
  int          em_cyc[$];

  int checks = 0, failures = 0;
  int cyc = 0, lat = 1, last_due = -1;
  int rdy_pct = 100, ordy_pct = 100;
  int live = 0, n_acc = 0, n_pops = 0;
  logic [11:0] exp_req = '0, exp_pc = '0;
  logic        s_req_valid, s_out_valid;
  logic [11:0] s_req_addr, s_out_pc;
  logic [31:0] s_out_instr;

  function automatic logic [31:0] memfn(input logic [11:0] a);
    return {20'hACE5A, a};
  endfunction

  // One clock cycle: drive at negedge, sample 1 time unit later, update model.
  task automatic tick(input logic redir, input logic [11:0] tgt);
    mreq_t m;
    req_ready   = ($urandom_range(99) < rdy_pct);
    out_ready   = ($urandom_range(99) < ordy_pct);
    resp_valid  = (pend.size() != 0) && (pend[0].due <= cyc);
    resp_data   = resp_valid ? memfn(pend[0].addr) : $urandom;
    redirect    = redir;
    redirect_pc = redir ? tgt : 12'($urandom);
    #1;
    s_req_valid = req_valid;
    s_req_addr  = req_addr;
    s_out_valid = out_valid;
    s_out_pc    = out_pc;
    s_out_instr = out_instr;
    if (resp_valid) void'(pend.pop_front());
    if (req_valid) begin
      checks++;
      if (req_addr !== exp_req) begin
        failures++;
        $display("FAIL req_addr cyc=%0d got=%h exp=%h", cyc, req_addr, exp_req);
      end
    end
    if (req_valid && req_ready) begin
      m.addr   = req_addr;
      m.due    = (cyc + lat > last_due) ? cyc + lat : last_due + 1;
      last_due = m.due;
      pend.push_back(m);
      n_acc++;
      if (!redir) begin
        exp_req += 12'd4;
        live++;
      end
    end
    if (out_valid && out_ready && !redir) begin
      checks++;
      if (out_pc !== exp_pc || out_instr !== memfn(exp_pc)) begin
        failures++;
        $display("FAIL pop cyc=%0d got pc=%h instr=%h exp pc=%h instr=%h",
                 cyc, out_pc, out_instr, exp_pc, memfn(exp_pc));
      end
      em_pc.push_back(out_pc);
      em_cyc.push_back(cyc);
      exp_pc += 12'd4;
      live--;
      n_pops++;
    end
    checks++;
    if (live > DEPTH) begin
      failures++;
      $display("FAIL occupancy cyc=%0d got=%0d max=%0d", cyc, live, DEPTH);
    end
    if (redir) begin
      exp_req = tgt;
      exp_pc  = tgt;
      live    = 0;
      em_pc.delete();
      em_cyc.delete();
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic model_reset();
    exp_req = 12'h000;
    exp_pc  = 12'h000;
    live    = 0;
    em_pc.delete();
    em_cyc.delete();
  endtask

  // Reset long enough for the memory to drain, release, then the BOOT cycle.
  task automatic restart();
    rst_n = 1'b0;
    repeat (6) tick(1'b0, 12'h0);
    model_reset();
    rst_n = 1'b1;
    tick(1'b0, 12'h0);
  endtask

  task automatic test_reset();
    lat = 3; rdy_pct = 100; ordy_pct = 0;
    rst_n = 1'b0;
    tick(1'b0, 12'h0);
    checks++;
    if (s_out_valid !== 1'b0 || s_req_valid !== 1'b0) begin
      failures++;
      $display("FAIL por_valids got ov=%b rv=%b exp 0 0", s_out_valid, s_req_valid);
    end
    checks++;
    if (s_out_instr !== 32'h0 || s_out_pc !== 12'h0) begin
      failures++;
      $display("FAIL por_head got instr=%h pc=%h exp 0 0", s_out_instr, s_out_pc);
    end
    repeat (5) tick(1'b0, 12'h0);
    model_reset();
    rst_n = 1'b1;
    tick(1'b0, 12'h0);
    checks++;
    if (s_req_valid !== 1'b0) begin
      failures++;
      $display("FAIL boot_req got=%b exp=0", s_req_valid);
    end
    tick(1'b0, 12'h0);
    checks++;
    if (s_req_valid !== 1'b1 || s_req_addr !== 12'h000) begin
      failures++;
      $display("FAIL first_req got rv=%b addr=%h exp 1 000", s_req_valid, s_req_addr);
    end
    // Fill the queue, then reset in the middle of operation.
    repeat (10) tick(1'b0, 12'h0);
    checks++;
    if (s_out_valid !== 1'b1) begin
      failures++;
      $display("FAIL prefill got ov=%b exp=1", s_out_valid);
    end
    rst_n = 1'b0;
    tick(1'b0, 12'h0);
    tick(1'b0, 12'h0);
    checks++;
    if (s_out_valid !== 1'b0 || s_req_valid !== 1'b0) begin
      failures++;
      $display("FAIL midrun_rst got ov=%b rv=%b exp 0 0", s_out_valid, s_req_valid);
    end
    repeat (5) tick(1'b0, 12'h0);
    model_reset();
    rst_n = 1'b1;
    tick(1'b0, 12'h0);
    tick(1'b0, 12'h0);
    checks++;
    if (s_req_valid !== 1'b1 || s_req_addr !== 12'h000) begin
      failures++;
      $display("FAIL rerun_req got rv=%b addr=%h exp 1 000", s_req_valid, s_req_addr);
    end
  endtask

  task automatic test_stream();
    int c1;
    lat = 1; rdy_pct = 100; ordy_pct = 100;
    restart();
    c1 = cyc;
    repeat (10) tick(1'b0, 12'h0);
    checks++;
    if (em_pc.size() < 3) begin
      failures++;
      $display("FAIL stream_count got=%0d exp>=3", em_pc.size());
    end else begin
      checks++;
      if (em_pc[0] !== 12'h000 || em_pc[1] !== 12'h004 || em_pc[2] !== 12'h008) begin
        failures++;
        $display("FAIL stream_pcs got=%h,%h,%h exp=000,004,008", em_pc[0], em_pc[1], em_pc[2]);
      end
      checks++;
      if (em_cyc[0] != c1 + 2 || em_cyc[1] != c1 + 3 || em_cyc[2] != c1 + 4) begin
        failures++;
        $display("FAIL stream_cycles got=%0d,%0d,%0d exp=%0d,%0d,%0d",
                 em_cyc[0], em_cyc[1], em_cyc[2], c1 + 2, c1 + 3, c1 + 4);
      end
    end
  endtask

  task automatic test_full();
    int a0;
    lat = 1; rdy_pct = 100; ordy_pct = 0;
    restart();
    a0 = n_acc;
    repeat (12) tick(1'b0, 12'h0);
    checks++;
    if (n_acc - a0 != DEPTH) begin
      failures++;
      $display("FAIL full_accepts got=%0d exp=%0d", n_acc - a0, DEPTH);
    end
    checks++;
    if (s_req_valid !== 1'b0) begin
      failures++;
      $display("FAIL full_reqv got=%b exp=0", s_req_valid);
    end
    ordy_pct = 100;
    tick(1'b0, 12'h0);
    checks++;
    if (em_pc.size() != 1 || s_req_valid !== 1'b0) begin
      failures++;
      $display("FAIL full_pop got pops=%0d rv=%b exp 1 0", em_pc.size(), s_req_valid);
    end
    ordy_pct = 0;
    tick(1'b0, 12'h0);
    checks++;
    if (s_req_valid !== 1'b1) begin
      failures++;
      $display("FAIL full_resume got=%b exp=1", s_req_valid);
    end
  endtask

  task automatic test_redirect();
    int c1;
    lat = 4; rdy_pct = 100; ordy_pct = 100;
    restart();
    c1 = cyc;
    repeat (3) tick(1'b0, 12'h0);
    rdy_pct = 0;
    tick(1'b1, 12'h100);
    rdy_pct = 100;
    repeat (16) tick(1'b0, 12'h0);
    checks++;
    if (em_pc.size() == 0) begin
      failures++;
      $display("FAIL redir_none got=0 exp>0");
    end else begin
      checks++;
      if (em_pc[0] !== 12'h100 || em_cyc[0] != c1 + 12) begin
        failures++;
        $display("FAIL redir_first got pc=%h cyc=%0d exp pc=100 cyc=%0d",
                 em_pc[0], em_cyc[0], c1 + 12);
      end
    end
  endtask

  task automatic test_wrap();
    int r;
    lat = 2; rdy_pct = 100; ordy_pct = 0;
    restart();
    repeat (10) tick(1'b0, 12'h0);
    ordy_pct = 100;
    r = cyc;
    tick(1'b1, 12'hFF8);
    repeat (10) tick(1'b0, 12'h0);
    checks++;
    if (em_pc.size() < 3) begin
      failures++;
      $display("FAIL wrap_count got=%0d exp>=3", em_pc.size());
    end else begin
      checks++;
      if (em_pc[0] !== 12'hFF8 || em_pc[1] !== 12'hFFC || em_pc[2] !== 12'h000) begin
        failures++;
        $display("FAIL wrap_pcs got=%h,%h,%h exp=ff8,ffc,000", em_pc[0], em_pc[1], em_pc[2]);
      end
      checks++;
      if (em_cyc[0] != r + 2 + lat) begin
        failures++;
        $display("FAIL redir_latency got=%0d exp=%0d", em_cyc[0] - r, 2 + lat);
      end
    end
  endtask

  task automatic test_back_to_back();
    int c1;
    lat = 4; rdy_pct = 100; ordy_pct = 100;
    restart();
    c1 = cyc;
    repeat (3) tick(1'b0, 12'h0);
    rdy_pct = 0;
    tick(1'b1, 12'h040);
    tick(1'b1, 12'h080);
    rdy_pct = 100;
    repeat (16) tick(1'b0, 12'h0);
    checks++;
    if (em_pc.size() == 0) begin
      failures++;
      $display("FAIL b2b_none got=0 exp>0");
    end else begin
      checks++;
      if (em_pc[0] !== 12'h080 || em_cyc[0] != c1 + 12) begin
        failures++;
        $display("FAIL b2b_first got pc=%h cyc=%0d exp pc=080 cyc=%0d",
                 em_pc[0], em_cyc[0], c1 + 12);
      end
    end
  endtask

  task automatic test_random();
    int p0;
    logic [11:0] t;
    rdy_pct = 70; ordy_pct = 60;
    restart();
    p0 = n_pops;
    for (int ph = 0; ph < 8; ph++) begin
      lat = $urandom_range(4, 1);
      for (int i = 0; i < 200; i++) begin
        t = 12'($urandom) & 12'hFFC;
        tick($urandom_range(99) < 5, t);
      end
    end
    checks++;
    if (n_pops - p0 < 100) begin
      failures++;
      $display("FAIL random_progress got=%0d exp>=100", n_pops - p0);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_stream();
    test_full();
    test_redirect();
    test_wrap();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
